rep_code_tx: RTL and testbench

- Serial transmitter for the rate-1/REP repetition code.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits it LSB first.
- Each data bit is repeated REP consecutive accepted slots, so the receive side can recover it with a per-bit majority vote over REP samples.
- Sits between the parallel data source and the serial link.

---
 rtl/rep_code_pkg.sv | 22 ++
 rtl/rep_code_tx_slot_counter.sv | 44 ++++
 rtl/rep_code_tx.sv | 125 ++++++++++++
 tb/tb_rep_code_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rep_code_pkg.sv
// rep_code_pkg
//   Shared types and helpers for the repetition-code serial transmitter.
//   - state_t        : transmitter FSM states
//   - REP_DEFAULT    : default repetitions per data bit
//   - DATA_W_DEFAULT : default word width
//   - rep_cnt_w()    : width of a modulo-N slot counter (minimum 1 bit)
package rep_code_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int REP_DEFAULT    = 3;
    localparam int DATA_W_DEFAULT = 8;

    // A modulo-1 counter still needs one bit so the port is never zero-width.
    function automatic int rep_cnt_w(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/rep_code_tx_slot_counter.sv
// rep_slot_counter
//   Modulo-MOD up-counter used for both the repetition slot and the bit index.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous active-high reset, count -> 0
//     clear    in   synchronous clear, count -> 0 (wins over advance)
//     advance  in   step the counter by one
//     count    out  current count, 0 .. MOD-1
//     terminal out  count == MOD-1 while advancing (wrap event)
module rep_slot_counter
    import rep_code_pkg::*;
#(
    parameter int MOD = REP_DEFAULT,
    parameter int W   = rep_cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         terminal
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_count;
    logic         w_at_last;

    assign w_at_last = (r_count == LAST);
    assign count     = r_count;
    assign terminal  = w_at_last && advance;

    // Wrapping to 0 at LAST keeps the counter from ever exceeding MOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (advance) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/rep_code_tx.sv
// rep_code_tx
//   Repetition-code serial transmitter. Accepts a DATA_W-bit word over a
//   valid/ready handshake and sends it LSB first, each bit repeated REP
//   consecutive accepted slots so the receiver can majority-vote per bit.
//   Ports:
//     clk          in   rising-edge clock
//     rst          in   synchronous active-high reset (aborts any frame)
//     in_valid     in   upstream word available
//     in_ready     out  word accepted this cycle when in_valid is also high
//     in_data      in   word to send, sampled on in_valid && in_ready
//     ser_valid    out  ser_out carries a coded symbol
//     out_ready    in   downstream consumes the current symbol
//     ser_out      out  coded serial symbol
//     frame_start  out  current symbol is slot 0 of bit 0
//     frame_last   out  current symbol is slot REP-1 of bit DATA_W-1
//     busy         out  a word is in flight
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word held; in_ready high, serial side quiet
//   SEND  | shifting out the held word; one slot per ser_valid&&out_ready
module rep_code_tx
    import rep_code_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REP    = REP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_valid,
    input  logic              out_ready,
    output logic              ser_out,
    output logic              frame_start,
    output logic              frame_last,
    output logic              busy
);

    localparam int REP_W = rep_cnt_w(REP);
    localparam int BIT_W = rep_cnt_w(DATA_W);

    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    if ((REP < 1) || ((REP % 2) == 0)) begin : g_bad_rep
        $error("rep_code_tx: REP must be odd and >= 1");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("rep_code_tx: DATA_W must be >= 1");
    end

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;

    logic              w_send;
    logic              w_slot_done;
    logic              w_accept;
    logic              w_frame_last;
    logic [REP_W-1:0]  w_rep_cnt;
    logic [BIT_W-1:0]  w_bit_cnt;
    logic              w_rep_term;
    logic              w_bit_term;

    assign w_send      = (r_state == SEND);
    assign w_slot_done = w_send && out_ready;

    assign w_frame_last = w_send && (w_bit_cnt == BIT_LAST) && (w_rep_cnt == REP_LAST);

    // Ready in the final slot only when that slot is actually completing,
    // which lets the next word load with no idle bubble on the link.
    assign in_ready = !rst && (!w_send || (w_frame_last && out_ready));
    assign w_accept = in_valid && in_ready;

    rep_slot_counter #(
        .MOD (REP),
        .W   (REP_W)
    ) u_rep_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_accept),
        .advance  (w_slot_done),
        .count    (w_rep_cnt),
        .terminal (w_rep_term)
    );

    rep_slot_counter #(
        .MOD (DATA_W),
        .W   (BIT_W)
    ) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_accept),
        .advance  (w_rep_term),
        .count    (w_bit_cnt),
        .terminal (w_bit_term)
    );

    // w_bit_term fires exactly when the frame_last slot completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
        end else if (w_accept) begin
            r_state <= SEND;
            r_shift <= in_data;
        end else begin
            if (w_rep_term) begin
                r_shift <= r_shift >> 1;
            end
            if (w_bit_term) begin
                r_state <= IDLE;
            end
        end
    end

    // All serial-side outputs come from registered state only.
    assign ser_valid   = w_send;
    assign busy        = w_send;
    assign ser_out     = w_send && r_shift[0];
    assign frame_start = w_send && (w_bit_cnt == '0) && (w_rep_cnt == '0);
    assign frame_last  = w_frame_last;

endmodule

// File: tb/tb_rep_code_tx.sv
module tb_rep_code_tx;

    localparam int DW   = 8;
    localparam int RP   = 3;
    localparam int NSYM = DW * RP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       a_in_valid, a_in_ready, a_ser_valid, a_out_ready, a_ser_out;
    logic       a_fs, a_fl, a_busy;
    logic [7:0] a_in_data;

    logic       b_in_valid, b_in_ready, b_ser_valid, b_out_ready, b_ser_out;
    logic       b_fs, b_fl, b_busy;
    logic [3:0] b_in_data;

    int n_checks = 0;
    int n_fail   = 0;

    rep_code_tx #(.DATA_W(DW), .REP(RP)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .ser_valid(a_ser_valid), .out_ready(a_out_ready), .ser_out(a_ser_out),
        .frame_start(a_fs), .frame_last(a_fl), .busy(a_busy)
    );

    rep_code_tx #(.DATA_W(4), .REP(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .ser_valid(b_ser_valid), .out_ready(b_out_ready), .ser_out(b_ser_out),
        .frame_start(b_fs), .frame_last(b_fl), .busy(b_busy)
    );

    typedef struct {
        logic [7:0]      data;
        int              mode;
        int              cycles;
        logic [NSYM-1:0] syms;    // symbol k at bit NSYM-1-k
        string           name;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_at(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    // Starts with the DUT idle; sends one word and checks every cycle.
    task automatic run_frame(input logic [7:0] data, input int mode,
                             input logic [NSYM-1:0] exp, input int exp_cycles,
                             input string nm);
        int k = 0;
        int c = 0;
        a_in_valid  = 1'b1;
        a_in_data   = data;
        a_out_ready = 1'b1;
        #1;
        chk({nm, "_accept_ready"}, a_in_ready, 1);
        step();
        a_in_valid = 1'b0;
        while (k < NSYM && c < 200) begin
            a_in_data   = 8'($urandom);
            a_out_ready = ready_at(mode, c);
            #1;
            chk({nm, "_valid"}, a_ser_valid, 1);
            chk({nm, "_busy"},  a_busy, 1);
            chk({nm, "_sym"},   a_ser_out, exp[NSYM-1-k]);
            chk({nm, "_fs"},    a_fs, (k == 0));
            chk({nm, "_fl"},    a_fl, (k == NSYM-1));
            if (k < NSYM-1) chk({nm, "_inrdy_low"}, a_in_ready, 0);
            if (a_out_ready) k++;
            c++;
            step();
        end
        chk({nm, "_cycles"}, c, exp_cycles);
        chk({nm, "_end_valid"}, a_ser_valid, 0);
        chk({nm, "_end_busy"},  a_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit q[$];

        vecs[0] = '{8'hA5, 0, 24, 24'b111_000_111_000_000_111_000_111, "a5_full"};
        vecs[1] = '{8'h3C, 1, 48, 24'b000_000_111_111_111_111_000_000, "3c_stall"};
        vecs[2] = '{8'h80, 0, 24, 24'b000_000_000_000_000_000_000_111, "80_full"};
        vecs[3] = '{8'h01, 1, 48, 24'b111_000_000_000_000_000_000_000, "01_stall"};

        // Reset with in_valid held high
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 8'hFF; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 4'hF;  b_out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready",  a_in_ready, 0);
        chk("rst_ser_valid", a_ser_valid, 0);
        chk("rst_busy",      a_busy, 0);
        chk("rst_ser_out",   a_ser_out, 0);
        chk("rst_fs_fl",     {a_fs, a_fl}, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready",  a_in_ready, 1);
        chk("post_rst_ser_valid", a_ser_valid, 0);
        step();

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].data, vecs[i].mode, vecs[i].syms, vecs[i].cycles, vecs[i].name);
        end

        // Back-to-back 0xFF then 0x00
        begin
            int k = 0;
            int c = 0;
            a_in_valid = 1'b1; a_in_data = 8'hFF; a_out_ready = 1'b1;
            #1;
            chk("b2b_accept_ready", a_in_ready, 1);
            step();
            a_in_data = 8'h00;
            while (k < 2*NSYM && c < 200) begin
                #1;
                chk("b2b_valid", a_ser_valid, 1);
                chk("b2b_sym",   a_ser_out, (k < NSYM));
                chk("b2b_fs",    a_fs, (k == 0 || k == NSYM));
                chk("b2b_fl",    a_fl, (k == NSYM-1 || k == 2*NSYM-1));
                if (a_in_valid) chk("b2b_in_ready", a_in_ready, (k == NSYM-1));
                k++;
                c++;
                step();
                if (k == NSYM) a_in_valid = 1'b0;
            end
            chk("b2b_cycles", c, 2*NSYM);
            chk("b2b_end_busy", a_busy, 0);
        end

        // Reset on symbol 10 of 0xA5, then a fresh 0x01
        a_in_valid = 1'b1; a_in_data = 8'hA5; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("abort_sym", a_ser_out, vecs[0].syms[NSYM-1-k]);
            if (k == 9) rst = 1'b1;
            step();
        end
        chk("abort_ser_valid", a_ser_valid, 0);
        chk("abort_busy",      a_busy, 0);
        chk("abort_in_ready",  a_in_ready, 0);
        rst = 1'b0;
        #1;
        chk("abort_idle_ready", a_in_ready, 1);
        chk("abort_fs", a_fs, 0);
        step();
        run_frame(8'h01, 0, 24'b111_000_000_000_000_000_000_000, 24, "after_abort");

        // REP=1, DATA_W=4 instance
        begin
            logic [3:0] bw[2];
            bw[0] = 4'h9;
            bw[1] = 4'hC;
            for (int w = 0; w < 2; w++) begin
                logic [3:0] exp_syms;
                exp_syms = (w == 0) ? 4'b1001 : 4'b1100;  // symbol k at bit k
                b_in_valid = 1'b1; b_in_data = bw[w]; b_out_ready = 1'b1;
                #1;
                chk("r1_accept_ready", b_in_ready, 1);
                step();
                b_in_valid = 1'b0;
                b_in_data  = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    #1;
                    chk("r1_valid", b_ser_valid, 1);
                    chk("r1_sym",   b_ser_out, exp_syms[k]);
                    chk("r1_fs",    b_fs, (k == 0));
                    chk("r1_fl",    b_fl, (k == 3));
                    step();
                end
                chk("r1_end_valid", b_ser_valid, 0);
            end
        end

        // Randomized traffic against a symbol-queue model
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit exp_rdy;
            int pos;
            a_in_valid  = ($urandom_range(0, 2) == 0);
            a_in_data   = 8'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() == 0) || (q.size() == 1 && a_out_ready);
            chk("rnd_in_ready",  a_in_ready, exp_rdy);
            chk("rnd_ser_valid", a_ser_valid, (q.size() != 0));
            chk("rnd_busy",      a_busy, (q.size() != 0));
            if (q.size() != 0) begin
                pos = NSYM - q.size();
                chk("rnd_sym", a_ser_out, q[0]);
                chk("rnd_fs",  a_fs, (pos == 0));
                chk("rnd_fl",  a_fl, (pos == NSYM-1));
                if (a_out_ready) void'(q.pop_front());
            end else begin
                chk("rnd_idle_out", {a_ser_out, a_fs, a_fl}, 0);
            end
            if (a_in_valid && exp_rdy) begin
                for (int i = 0; i < NSYM; i++) q.push_back(a_in_data[i / RP]);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
